// File: rtl/relm_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Requests enter on a start/ready handshake; results leave on a valid/ack handshake.
module relm_divider #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_in,
  input  logic          sign_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic          ready_out,
  output logic          valid_out,
  input  logic          ack_in,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          div0_out,
  output logic [2:0]    state_out
);

  // Handshakes: a request is taken on a rising edge where start_in=1 and
  // ready_out=1; a result is released on a rising edge where ack_in=1 and
  // valid_out=1. Both ready_out and valid_out come straight from the state register.

  localparam int CW = $clog2(WD);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_LOOP = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic [WD-1:0] n_raw_q;
  logic [WD-1:0] d_raw_q;
  logic          sign_q;
  logic [WD-1:0] nmag_q;
  logic [WD-1:0] dmag_q;
  logic [WD-1:0] rem_q;
  logic [WD-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          qneg_q;
  logic          rneg_q;
  logic          div0_q;
  logic [WD-1:0] q_out_q;
  logic [WD-1:0] r_out_q;
  logic          div0_out_q;

  logic [WD-1:0] n_abs_d;
  logic [WD-1:0] d_abs_d;
  logic [WD:0]   rem_sh_d;
  logic          rem_ge_d;
  logic [WD-1:0] rem_sub_d;

  assign n_abs_d = (sign_q && n_raw_q[WD-1]) ? -n_raw_q : n_raw_q;
  assign d_abs_d = (sign_q && d_raw_q[WD-1]) ? -d_raw_q : d_raw_q;

  // The shifted remainder is WD+1 bits wide; after a subtraction it always fits
  // back into WD bits because it ends up strictly below the divisor magnitude.
  assign rem_sh_d  = {rem_q, nmag_q[WD-1]};
  assign rem_ge_d  = rem_sh_d >= {1'b0, dmag_q};
  assign rem_sub_d = rem_sh_d[WD-1:0] - dmag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_raw_q    <= '0;
      d_raw_q    <= '0;
      sign_q     <= 1'b0;
      nmag_q     <= '0;
      dmag_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      div0_q     <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      div0_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            n_raw_q <= n_in;
            d_raw_q <= d_in;
            sign_q  <= sign_in;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          nmag_q <= n_abs_d;
          dmag_q <= d_abs_d;
          cnt_q  <= '0;
          if (d_raw_q == '0) begin
            // Divide by zero bypasses the loop and the sign fix entirely.
            quo_q   <= '1;
            rem_q   <= n_raw_q;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b1;
            state_q <= S_FIX;
          end else begin
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= sign_q & (n_raw_q[WD-1] ^ d_raw_q[WD-1]);
            rneg_q  <= sign_q & n_raw_q[WD-1];
            div0_q  <= 1'b0;
            state_q <= S_LOOP;
          end
        end
        S_LOOP: begin
          nmag_q <= nmag_q << 1;
          if (rem_ge_d) begin
            rem_q <= rem_sub_d;
            quo_q <= {quo_q[WD-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh_d[WD-1:0];
            quo_q <= {quo_q[WD-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WD - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          q_out_q    <= qneg_q ? -quo_q : quo_q;
          r_out_q    <= rneg_q ? -rem_q : rem_q;
          div0_out_q <= div0_q;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          if (ack_in) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = (state_q == S_DONE);
  assign q_out     = q_out_q;
  assign r_out     = r_out_q;
  assign div0_out  = div0_out_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_relm_divider.sv
// Self-checking bench for relm_divider: directed cases plus randomized requests
// checked against an arithmetic reference model and a per-cycle result monitor.
module tb_relm_divider;

  localparam int WD = 32;
  localparam int RW = 2 * WD + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic          sign_in = 1'b0;
  logic [WD-1:0] n_in = '0;
  logic [WD-1:0] d_in = '0;
  logic          ack_in = 1'b0;
  logic          ready_out;
  logic          valid_out;
  logic [WD-1:0] q_out;
  logic [WD-1:0] r_out;
  logic          div0_out;
  logic [2:0]    state_out;

  int n_vec = 0;
  int n_err = 0;

  // Expected results, packed as {div0, q, r}.
  logic [RW-1:0] exp_q[$];

  relm_divider #(.WD(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .sign_in   (sign_in),
    .n_in      (n_in),
    .d_in      (d_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ack_in    (ack_in),
    .q_out     (q_out),
    .r_out     (r_out),
    .div0_out  (div0_out),
    .state_out (state_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [WD-1:0] n, input logic [WD-1:0] d,
                                          input logic s);
    longint sn, sd, qq, rr;
    if (d == '0) return {1'b1, {WD{1'b1}}, n};
    if (s) begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
    end else begin
      sn = longint'({32'b0, n});
      sd = longint'({32'b0, d});
    end
    qq = sn / sd;
    rr = sn % sd;
    return {1'b0, qq[WD-1:0], rr[WD-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] outs();
    return {div0_out, q_out, r_out};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) begin
        chk("valid_without_request", RW'(valid_out), RW'(0));
      end else begin
        chk("monitor_result", outs(), exp_q[0]);
        chk("monitor_ready_low", RW'(ready_out), RW'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_div(input logic [WD-1:0] n, input logic [WD-1:0] d, input logic s,
                         input int hold, output logic [RW-1:0] got);
    int lat;
    logic [RW-1:0] snap;
    chk("ready_before_start", RW'(ready_out), RW'(1));
    n_in = n;
    d_in = d;
    sign_in = s;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    exp_q.push_back(model(n, d, s));
    n_in = $urandom;
    d_in = $urandom;
    sign_in = $urandom_range(0, 1);
    lat = 0;
    while (!valid_out && lat < 100) begin
      if (ready_out) chk("ready_low_busy", RW'(ready_out), RW'(0));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", RW'(lat), (d == '0) ? RW'(2) : RW'(WD + 2));
    snap = outs();
    for (int i = 0; i < hold; i++) begin
      start_in = $urandom_range(0, 1);
      n_in = $urandom;
      d_in = $urandom;
      sign_in = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      chk("hold_outputs", outs(), snap);
      chk("hold_valid_ready", RW'({valid_out, ready_out}), RW'(2'b10));
    end
    start_in = $urandom_range(0, 1);
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    start_in = 1'b0;
    chk("after_ack_valid_ready", RW'({valid_out, ready_out}), RW'(2'b01));
    chk("after_ack_outputs_kept", outs(), snap);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    got = snap;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [RW-1:0] got;
    logic [WD-1:0] rn, rd;
    logic rs;
    int lat;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {ready_out, valid_out, q_out, r_out, div0_out}, {1'b1, 1'b0, {WD{1'b0}}, {WD{1'b0}}, 1'b0});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("model_100_7", model(32'd100, 32'd7, 1'b0), {1'b0, 32'd14, 32'd2});
    chk("model_m7_2", model(32'hFFFFFFF9, 32'd2, 1'b1), {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF});
    chk("model_min_m1", model(32'h80000000, 32'hFFFFFFFF, 1'b1), {1'b0, 32'h80000000, 32'd0});
    chk("model_div0", model(32'd5, 32'd0, 1'b1), {1'b1, 32'hFFFFFFFF, 32'd5});

    run_div(32'd100, 32'd7, 1'b0, 10, got);
    chk("plan_100_7", got, {1'b0, 32'd14, 32'd2});
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1, got);
    chk("plan_m7_2", got, {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF});
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, got);
    chk("plan_7_m2", got, {1'b0, 32'hFFFFFFFD, 32'd1});
    run_div(32'd5, 32'd0, 1'b1, 2, got);
    chk("plan_div0", got, {1'b1, 32'hFFFFFFFF, 32'd5});
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, got);
    chk("plan_min_m1", got, {1'b0, 32'h80000000, 32'd0});
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, got);
    chk("plan_max_1", got, {1'b0, 32'hFFFFFFFF, 32'd0});
    run_div(32'd3, 32'hFFFFFFFF, 1'b0, 0, got);
    chk("plan_3_max", got, {1'b0, 32'd0, 32'd3});

    // Reset in the middle of a divide: asserted for edge 10 after the accept edge.
    n_in = 32'd1000;
    d_in = 32'd3;
    sign_in = 1'b0;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    lat = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("midop_reset", {ready_out, valid_out, q_out, r_out, div0_out}, {1'b1, 1'b0, {WD{1'b0}}, {WD{1'b0}}, 1'b0});
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_abort", RW'({valid_out, ready_out}), RW'(2'b01));
    end
    run_div(32'd9, 32'd3, 1'b0, 0, got);
    chk("plan_9_3_after_reset", got, {1'b0, 32'd3, 32'd0});

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: rn = 32'h80000000;
        1: rn = $urandom_range(0, 50);
        default: rn = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rd = 32'd0;
        1: rd = $urandom_range(1, 15);
        2: rd = 32'hFFFFFFFF;
        default: rd = $urandom;
      endcase
      rs = $urandom_range(0, 1);
      run_div(rn, rd, rs, $urandom_range(0, 3), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/relm_divider.md
# relm_divider

Iterative hardware integer divider for the ReLM soft-processor datapath. It computes the quotient and remainder of a WD-bit dividend and divisor, signed or unsigned. It uses a radix-2 restoring loop with one quotient bit per clock. The block accepts requests from the custom-instruction front end over a start/ready handshake and returns results over a valid/ack handshake, so software no longer has to sequence division steps itself.

## Interface
- WD, 32, operand and result width; must be even and ≥ 4.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start_in  in  1  request strobe; accepted only when ready_out=1.
- sign_in  in  1  1 = two's-complement signed division, 0 = unsigned; sampled with start_in.
- n_in  in  WD  dividend N; sampled on the accept edge.
- d_in  in  WD  divisor D; sampled on the accept edge.
- ready_out  out  1  idle, can accept a request.
- valid_out  out  1  q_out/r_out/div0_out hold a completed result.
- ack_in  in  1  consumer takes result; effective only when valid_out=1.
- q_out  out  WD  quotient.
- r_out  out  WD  remainder.
- div0_out  out  1  result came from D=0.

## Operation
- States:
  - IDLE: ready_out=1.
  - PREP: form magnitudes, detect D=0.
  - LOOP: WD iterations.
  - FIX: apply signs.
  - DONE: valid_out=1, hold until acknowledged.
- Accept: edge with state=IDLE, start_in=1. Registers N, D, sign_in; IDLE→PREP. start_in is ignored in every other state.
- PREP:
  - If sign_in and the operand MSB is 1, the magnitude is its two's-complement negation (MIN stays 2^(WD-1) as unsigned).
  - Record qneg = sign_in & (N[WD-1]^D[WD-1]) and rneg = sign_in & N[WD-1].
  - Clear the partial remainder (WD+1 bits) and the bit counter.
  - If D=0: q = all ones, r = N (raw input), div0 = 1; PREP→FIX with sign fix suppressed.
  - Otherwise PREP→LOOP.
- LOOP, each edge:
  - rem ← {rem[WD-1:0], nmag[WD-1]}; nmag ← nmag<<1.
  - If rem ≥ {0,dmag}: rem ← rem − dmag and shift 1 into q; otherwise shift 0.
  - The compare is WD+1 bits, unsigned.
  - Counter 0..WD-1; on count=WD-1, LOOP→FIX.
- FIX:
  - q_out ← qneg ? −q : q; r_out ← rneg ? −rem[WD-1:0] : rem[WD-1:0].
  - div0_out latched; FIX→DONE.
- Rounding is truncation toward zero, and the remainder has the sign of N (|r| < |D|).
- Signed MIN / −1 needs no special case: q = MIN and r = 0 (wraps).
- DONE:
  - valid_out=1; q_out, r_out and div0_out are stable.
  - On an edge with ack_in=1: DONE→IDLE. Outputs keep their last values; valid_out drops.
  - ack_in when valid_out=0 is ignored.

## Timing
- Reset values: state=IDLE, ready_out=1, valid_out=0, q_out=0, r_out=0, div0_out=0; all internal registers cleared.
- While rst_n=0 at an edge, start_in and ack_in are ignored.
- Reset in any state aborts the operation: no valid_out pulse, and ready_out=1 after the reset edge.
- ready_out and valid_out are decoded from registered state only, with no combinational path from inputs.
- Latency is counted from the accept edge (edge 0):
  - Normal: edge 1 PREP→LOOP, edges 2..WD+1 LOOP, edge WD+2 FIX→DONE. valid_out is high after edge WD+2 (34 for WD=32).
  - D=0: valid_out is high after edge 2.
- Minimum request-to-request spacing is 1 cycle in IDLE after the ack edge. An ack edge makes ready_out=1 in the next cycle; start_in is not accepted on the ack edge itself.
- Backpressure: DONE may last indefinitely; outputs must not change until the ack edge.

## Test plan
- Unsigned: N=100, D=7, sign=0 → valid after edge 34, q=14, r=2, div0=0; ready_out=0 from edge 0 until the ack edge.
- Signed: N=0xFFFFFFF9 (−7), D=2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Also N=7, D=0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- Divide-by-zero: N=5, D=0, sign=1 → valid after edge 2, q=0xFFFFFFFF, r=5, div0=1.
- Overflow/extremes:
  - Signed N=0x80000000, D=0xFFFFFFFF → q=0x80000000, r=0.
  - Unsigned N=0xFFFFFFFF, D=1 → q=0xFFFFFFFF, r=0.
  - Unsigned N=3, D=0xFFFFFFFF → q=0, r=3.
- Handshake:
  - Hold ack_in=0 for 10 cycles in DONE while toggling start_in and changing n_in/d_in → outputs unchanged, no new accept.
  - ack_in=1 for one edge → valid_out=0, ready_out=1; next start accepted.
- Reset mid-operation: rst_n=0 at edge 10 of a divide → ready_out=1 and valid_out=0 after that edge, q_out=r_out=0. A following 9/3 request returns q=3, r=0.
